slice_add_seq: RTL and testbench

SLICE_ADD_SEQ -- requirements
Module: slice_add_seq

---
 rtl/add_ctrl_pkg.sv | 16 +
 rtl/multi_bit_adder.sv | 20 ++
 rtl/slice_add_seq.sv | 140 ++++++++++++++
 tb/tb_slice_add_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/add_ctrl_pkg.sv
// Shared constants and state encoding for the slice-serial adder.
package add_ctrl_pkg;

  // Default geometry: four 6-bit slices make a 24-bit word.
  localparam int SLICE_W = 6;
  localparam int NSLICE  = 4;
  localparam int WORD_W  = SLICE_W * NSLICE;

  // Controller states: waiting, adding one slice per cycle, result ready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : add_ctrl_pkg

// File: rtl/multi_bit_adder.sv
// Plain ripple adder of width W with carry-in and carry-out.
// Port names are kept as-is because other blocks already instantiate it.
module multi_bit_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry out falls into the top bit.
  logic [W:0] total;

  assign total = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, cin};
  assign sum   = total[W-1:0];
  assign cout  = total[W];

endmodule : multi_bit_adder

// File: rtl/slice_add_seq.sv
// Slice-serial adder: one SLICE_W-bit adder reused NSLICE times, least
// significant slice first, to form a WORD_W-bit sum plus carry out.
//
// Handshake: ready_o=1 means a start_i seen high at the next rising edge is
// accepted and a_i/b_i/cin_i are captured on that same edge. ready_o is low
// only while slices are being added; start_i is ignored then. done_o is a
// one-cycle pulse, NSLICE+1 cycles after the start cycle, during which
// sum_o/cout_o carry the fresh result; they hold it until the next accept.
// Both ready_o and done_o are pure state decodes, never paths from start_i.
module slice_add_seq
  import add_ctrl_pkg::*;
#(
  parameter  int SLICE_W = add_ctrl_pkg::SLICE_W,
  parameter  int NSLICE  = add_ctrl_pkg::NSLICE,
  localparam int WORD_W  = SLICE_W * NSLICE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o,
  output state_t            dbg_state_o
);

  // Slice index width; at least one bit so a single-slice build still works.
  localparam int          KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NSLICE - 1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [WORD_W-1:0]   a_q, a_d;
  logic [WORD_W-1:0]   b_q, b_d;
  logic                carry_q, carry_d;
  logic [WORD_W-1:0]   sum_q, sum_d;
  logic                cout_q, cout_d;

  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;

  // Current slice of each latched operand feeds the single adder.
  assign slice_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[k_q*SLICE_W +: SLICE_W];

  multi_bit_adder #(
    .W (SLICE_W)
  ) u_slice_adder (
    .A    (slice_a),
    .B    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and datapath update; every target defaults to holding.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          k_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Write this slice of the result and pass the carry to the next one.
        sum_d[k_q*SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        k_d     = k_q + 1'b1;
        if (k_q == LAST_K) begin
          cout_d  = slice_cout;
          k_d     = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        // A start here chains straight into the next addition.
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any addition in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign ready_o     = (state_q != RUN);
  assign done_o      = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign dbg_state_o = state_q;

endmodule : slice_add_seq

// File: tb/tb_slice_add_seq.sv
// Self-checking bench for slice_add_seq: vector table, corner-case
// sequences and a random stream, all results checked through a scoreboard.
module tb_slice_add_seq;
  import add_ctrl_pkg::*;

  localparam int W   = add_ctrl_pkg::WORD_W;
  localparam int LAT = add_ctrl_pkg::NSLICE + 1;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] sum_o;
  logic         cout_o;
  state_t       dbg_state_o;

  always #5 clk = ~clk;

  slice_add_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done_o) begin
      logic [W:0] e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 with sum %h, expected no pulse", sum_o);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({cout_o, sum_o}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W:0] exp);
    int g = 0;
    while (!ready_o && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    cin_i   = c;
    exp_q.push_back(exp);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // n0 = rising edges already seen since (and including) the accepting edge.
  task automatic wait_done(input string name, input int n0);
    int n = n0;
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 32'(done_o), 32'd1);
    check({name, "_latency"}, 32'(n), 32'(LAT));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    vecs[0] = '{24'h00003F, 24'h000001, 1'b0, 24'h000040, 1'b0};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b1};
    vecs[2] = '{24'h123456, 24'h654321, 1'b0, 24'h777777, 1'b0};
    vecs[3] = '{24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1};
    vecs[4] = '{24'h000FC0, 24'h000040, 1'b0, 24'h001000, 1'b0};
    vecs[5] = '{24'h000000, 24'h000000, 1'b1, 24'h000001, 1'b0};
    vecs[6] = '{24'hAAAAAA, 24'h555555, 1'b0, 24'hFFFFFF, 1'b0};
    vecs[7] = '{24'hAAAAAA, 24'h555555, 1'b1, 24'h000000, 1'b1};

    rst     = 1'b1;
    start_i = 1'b0;
    a_i     = '0;
    b_i     = '0;
    cin_i   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done",  32'(done_o),  32'd0);
    check("rst_sum",   32'(sum_o),   32'd0);
    check("rst_cout",  32'(cout_o),  32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(IDLE));

    // Table vectors, chained back to back from each DONE cycle.
    foreach (vecs[i]) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});
      check("run_ready_low", 32'(ready_o), 32'd0);
      wait_done("vec", 1);
    end

    // Result holds in IDLE after the pulse.
    @(negedge clk);
    check("hold_done", 32'(done_o), 32'd0);
    check("hold_state", 32'(dbg_state_o), 32'(IDLE));
    check("hold_sum", 32'(sum_o), 32'h000000);
    check("hold_cout", 32'(cout_o), 32'd1);

    // start_i during RUN is ignored.
    base = done_cnt;
    accept(24'h000010, 24'h000020, 1'b0, 25'h0000030);
    @(negedge clk);
    check("ignore_ready", 32'(ready_o), 32'd0);
    start_i = 1'b1;
    a_i     = 24'h000001;
    b_i     = 24'h000001;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("ignore", 3);
    repeat (8) @(negedge clk);
    check("ignore_single_done", 32'(done_cnt - base), 32'd1);

    // Reset on the second RUN cycle: no pulse, outputs cleared.
    base = done_cnt;
    accept(24'h000001, 24'h000002, 1'b0, 25'h0000003);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_done",  32'(done_o),  32'd0);
    check("midrst_sum",   32'(sum_o),   32'd0);
    check("midrst_cout",  32'(cout_o),  32'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    accept(24'd5, 24'd7, 1'b0, 25'd12);
    wait_done("after_rst", 1);

    // Back-to-back: new start taken in the DONE cycle.
    @(negedge clk);
    accept(24'd3, 24'd4, 1'b0, 25'd7);
    wait_done("b2b_first", 1);
    base = done_cnt;
    accept(24'h800000, 24'h800000, 1'b0, {1'b1, 24'h000000});
    check("b2b_reaccept_state", 32'(dbg_state_o), 32'(RUN));
    wait_done("b2b", 1);

    // Random stream against an arithmetic reference model.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      accept(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
      wait_done("rand", 1);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_slice_add_seq
